down_counter_6_load: RTL and testbench

Six-bit loadable down-counter/countdown timer for the SONAR timing chain, the counterpart to the free-running enabled up-counter. It is loaded with a count and decrements on enabled cycles to zero, then pulses `done`, either stopping (one-shot) or reloading (periodic). Ping burst lengths and listen-window timeouts use it.

---
 rtl/sonar_timer_pkg.sv | 17 +
 rtl/tick_prescaler.sv | 29 ++
 rtl/down_counter_6_load.sv | 90 +++++++++
 tb/tb_down_counter_6_load.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/sonar_timer_pkg.sv
// Shared types and defaults for the SONAR timing-chain counters.
package sonar_timer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int COUNTER_W_DEFAULT = 6;
  localparam int PRESCALE_DEFAULT  = 4;

  // Keep the prescaler at least one bit wide so PRESCALE=1 still elaborates.
  function automatic int prescale_w(input int p);
    return (p > 1) ? $clog2(p) : 1;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides enabled cycles by PRESCALE; tick marks the last enabled cycle of each group.
module tick_prescaler
  import sonar_timer_pkg::*;
#(
  parameter int PRESCALE = PRESCALE_DEFAULT
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int PW = prescale_w(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == LAST) ? '0 : cnt + PW'(1);
    end
  end

  assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/down_counter_6_load.sv
// Loadable down-counter / countdown timer, one-shot or periodic.
// Optional prescaler compiled in with DOWN_COUNTER_6_PRESCALE_EN.
module down_counter_6_load
  import sonar_timer_pkg::*;
#(
  parameter int WIDTH    = COUNTER_W_DEFAULT,
  parameter int PRESCALE = PRESCALE_DEFAULT
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             auto_reload,
  input  logic             stop,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);

  state_t           state;
  logic [WIDTH-1:0] reload;
  logic             periodic;
  logic             run_en;
  logic             tick;

  assign run_en = (state == RUN) && enable;

`ifdef DOWN_COUNTER_6_PRESCALE_EN
  logic pre_clear;

  // Terminal one-shot entry to IDLE needs no clear: the prescaler wraps to 0 on that tick.
  assign pre_clear = load || (stop && (state == RUN));

  tick_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_tick_prescaler (
    .clk   (clk),
    .resetn(resetn),
    .clear (pre_clear),
    .enable(run_en),
    .tick  (tick)
  );
`else
  logic unused_prescale;
  assign unused_prescale = ^PRESCALE;
  assign tick = run_en;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      q        <= '0;
      reload   <= '0;
      periodic <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        q      <= load_value;
        reload <= load_value;
        if (load_value == '0) begin
          state    <= IDLE;
          periodic <= 1'b0;
          done     <= 1'b1;
        end else begin
          state    <= RUN;
          periodic <= auto_reload;
        end
      end else if (stop && (state == RUN)) begin
        state <= IDLE;
      end else if (tick) begin
        if (q == WIDTH'(1)) begin
          done <= 1'b1;
          if (periodic) begin
            q <= reload;
          end else begin
            q     <= '0;
            state <= IDLE;
          end
        end else begin
          q <= q - WIDTH'(1);
        end
      end
    end
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_down_counter_6_load.sv
// Self-checking bench for down_counter_6_load; build with or without DOWN_COUNTER_6_PRESCALE_EN.
module tb_down_counter_6_load;

  localparam int WIDTH = 6;
`ifdef DOWN_COUNTER_6_PRESCALE_EN
  localparam int PS = 4;
`else
  localparam int PS = 1;
`endif

  logic             clk = 1'b0;
  logic             resetn;
  logic             enable;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             auto_reload;
  logic             stop;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;

  int n_checks = 0;
  int n_fail   = 0;

  down_counter_6_load #(.WIDTH(WIDTH), .PRESCALE(4)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .enable     (enable),
    .load       (load),
    .load_value (load_value),
    .auto_reload(auto_reload),
    .stop       (stop),
    .q          (q),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Reference: count of remaining ticks, a phase counter for enabled cycles, run flag.
  int m_q = 0, m_reload = 0, m_phase = 0;
  bit m_run = 0, m_periodic = 0, m_done = 0;

  always @(posedge clk) begin
    if (!resetn) begin
      m_q = 0; m_reload = 0; m_phase = 0; m_run = 0; m_periodic = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (load) begin
        m_q        = int'(load_value);
        m_reload   = int'(load_value);
        m_phase    = 0;
        m_run      = (load_value != 0);
        m_periodic = auto_reload && (load_value != 0);
        m_done     = (load_value == 0);
      end else if (stop && m_run) begin
        m_run   = 0;
        m_phase = 0;
      end else if (m_run && enable) begin
        m_phase = m_phase + 1;
        if (m_phase == PS) begin
          m_phase = 0;
          if (m_q == 1) begin
            m_done = 1;
            if (m_periodic) m_q = m_reload;
            else begin m_q = 0; m_run = 0; end
          end else begin
            m_q = m_q - 1;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_q", 32'(q), 32'(m_q));
    chk("model_busy", 32'(busy), 32'(m_run));
    chk("model_done", 32'(done), 32'(m_done));
  end

  task automatic step(input logic ld, input logic [WIDTH-1:0] lv, input logic ar,
                      input logic en, input logic st);
    load = ld; load_value = lv; auto_reload = ar; enable = en; stop = st;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input int eq, input int eb, input int ed);
    chk({name, "_q"}, 32'(q), 32'(eq));
    chk({name, "_busy"}, 32'(busy), 32'(eb));
    chk({name, "_done"}, 32'(done), 32'(ed));
  endtask

  initial begin
    resetn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 6'd20, 1'b0, 1'b1, 1'b0);
      chk_out("reset", 0, 0, 0);
    end
    resetn = 1'b1;
    step(1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
    chk_out("idle_after_reset", 0, 0, 0);

    // One-shot load 5
    step(1'b1, 6'd5, 1'b0, 1'b1, 1'b0);
    chk_out("oneshot_load", 5, 1, 0);
`ifndef DOWN_COUNTER_6_PRESCALE_EN
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 6'd0, 1'b0, 1'b1, 1'b0);
      chk_out("oneshot_run", 4 - i, (i < 4) ? 1 : 0, (i == 4) ? 1 : 0);
    end
    step(1'b0, 6'd0, 1'b0, 1'b1, 1'b0);
    chk_out("oneshot_after", 0, 0, 0);
`else
    for (int i = 0; i < 21; i++) step(1'b0, 6'd0, 1'b0, 1'b1, 1'b0);
`endif

    // Periodic load 3
    step(1'b1, 6'd3, 1'b1, 1'b1, 1'b0);
    chk_out("periodic_load", 3, 1, 0);
    for (int i = 0; i < 10 * PS; i++) begin
      step(1'b0, 6'd0, 1'b0, 1'b1, 1'b0);
`ifndef DOWN_COUNTER_6_PRESCALE_EN
      chk_out("periodic_run", 3 - ((i + 1) % 3), 1, ((i + 1) % 3 == 0) ? 1 : 0);
`endif
    end

    // Gating then stop
    step(1'b1, 6'd10, 1'b0, 1'b0, 1'b0);
    chk_out("gate_load", 10, 1, 0);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 6'd0, 1'b0, (i % 2 == 0), 1'b0);
`ifndef DOWN_COUNTER_6_PRESCALE_EN
      chk("gate_q", 32'(q), 32'(10 - (i / 2 + 1)));
`endif
    end
    step(1'b0, 6'd0, 1'b0, 1'b1, 1'b1);
`ifndef DOWN_COUNTER_6_PRESCALE_EN
    chk_out("stop", 6, 0, 0);
    step(1'b0, 6'd0, 1'b0, 1'b1, 1'b0);
    chk_out("stop_hold", 6, 0, 0);
`else
    step(1'b0, 6'd0, 1'b0, 1'b1, 1'b1);
`endif

    // Load zero: single done, stays idle
    step(1'b1, 6'd0, 1'b1, 1'b1, 1'b0);
    chk_out("load_zero", 0, 0, 1);
    step(1'b0, 6'd0, 1'b0, 1'b1, 1'b0);
    chk_out("load_zero_after", 0, 0, 0);

    // Load 7 coincident with a terminal tick
    step(1'b1, 6'd1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < PS - 1; i++) step(1'b0, 6'd0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 6'd7, 1'b0, 1'b1, 1'b0);
    chk_out("load_over_terminal", 7, 1, 0);

    // Load and stop together
    step(1'b1, 6'd9, 1'b0, 1'b1, 1'b1);
    chk_out("load_stop", 9, 1, 0);
    for (int i = 0; i < PS; i++) step(1'b0, 6'd0, 1'b0, 1'b1, 1'b0);
    chk_out("load_stop_count", 8, 1, 0);

    // Done latency: N*PS edges after the load edge
    step(1'b1, 6'd2, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 2 * PS; i++) begin
      step(1'b0, 6'd0, 1'b0, 1'b1, 1'b0);
      chk("latency_done", 32'(done), 32'(i == 2 * PS));
    end

    // Reset mid-count, with a terminal tick pending
    step(1'b1, 6'd1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < PS - 1; i++) step(1'b0, 6'd0, 1'b0, 1'b1, 1'b0);
    resetn = 1'b0;
    step(1'b0, 6'd0, 1'b0, 1'b1, 1'b0);
    chk_out("reset_mid", 0, 0, 0);
    resetn = 1'b1;
    step(1'b0, 6'd0, 1'b0, 1'b1, 1'b0);
    chk_out("reset_mid_after", 0, 0, 0);

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
